ps2_kbd_rx: RTL and testbench
=============================

# ps2_kbd_rx

PS/2 keyboard receiver that deserialises 11-bit device-to-host frames and buffers the validated scan-code bytes in a small FIFO. It sits directly upstream of the seven-segment display driver and supplies the codes that the display stage decodes and shows. Frames with bad framing or parity are counted and discarded. A stalled partial frame is abandoned after a timeout.

## Interface
Parameters:
- DEPTH, 8, FIFO depth in bytes; power of two, minimum 2.
- TIMEOUT, 50000, idle clk cycles with no ps2_clk falling edge before a partial frame is abandoned.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock from the keyboard; asynchronous to clk.
- ps2_data  input  1  raw PS/2 data from the keyboard; asynchronous to clk.
- nextdata_n  input  1  active-low pop request; read when ready=1.
- data  output  8  scan code at the FIFO head (show-ahead); 8'h00 when empty.
- ready  output  1  FIFO non-empty.
- overflow  output  1  sticky flag: a valid byte was dropped because the FIFO was full.
- err_cnt  output  8  saturating count of rejected frames.

## Operation
- **Synchronisers.** ps2_clk passes through a 3-flop synchroniser (s[2:0]). ps2_data passes through 2 flops.
  - A falling edge is detected in a cycle where s[2:1]==2'b10.
  - Synchronised data is sampled in that cycle.
- **Frame capture.**
  - A 4-bit bit counter cnt (0..10) and a 10-bit shift buffer buf.
  - On each detected falling edge with cnt<10: buf[cnt] <= data, cnt <= cnt+1.
  - On the edge with cnt==10 (stop bit): cnt <= 0 and the frame is checked.
    - buf[0]==0 (start bit).
    - stop sample==1.
    - ^buf[9:1]==1 (odd parity over data+parity).
- **Frame result.**
  - Check passes and FIFO not full: buf[8:1] (LSB first) is written at wptr, and wptr increments.
  - Check passes and FIFO full: the byte is dropped and overflow <= 1. A pop in the same cycle does not make room.
  - Check fails: no write; err_cnt increments and saturates at 8'hFF.
- **Timeout.** An idle counter clears on every detected edge and increments otherwise.
  - If cnt!=0 and the idle counter reaches TIMEOUT-1: cnt <= 0, idle counter clears, partial bits are discarded. No error is counted.
  - While cnt==0 the idle counter holds at 0.
- **FIFO.**
  - wptr and rptr are log2(DEPTH)+1 bits wide, and pointers wrap modulo 2·DEPTH.
  - empty when the pointers are equal.
  - full when the MSBs differ and the remaining bits are equal.
  - ready = !empty.
  - data = mem[rptr] when ready, else 8'h00.
- **Pop.** In a cycle with nextdata_n==0 and ready==1, rptr increments.
  - nextdata_n==0 while empty is ignored.
  - A pop and a write in the same cycle (FIFO not full) are both performed.
- **Overflow clear.** overflow clears only on rst. err_cnt clears only on rst.

## Timing
- Reset values: data=8'h00, ready=0, overflow=0, err_cnt=0. Internal state also resets: cnt=0, wptr=rptr=0, all synchroniser flops=1 (PS/2 idle high), idle counter=0.
- Reset mid-frame aborts the frame; the next falling edge after reset release is treated as a start bit.
- Edge-detect latency is 3 clk cycles from a pin-level ps2_clk fall. The input must hold each PS/2 phase for at least 4 clk cycles.
- Write latency: if the stop-bit edge is detected in cycle N, mem and wptr update at the end of N. ready rises and data is valid in N+1.
- Pop latency: with a pop in cycle M, data shows the next entry (or 8'h00 and ready=0) in M+1.
  - Holding nextdata_n low pops one entry per cycle.
- err_cnt and overflow update at the end of the stop-bit cycle N.

## Test plan
- **Single frame.** Send scan code 0x1C with parity=0 and stop=1 → ready=1, data=0x1C, err_cnt=0. Then pulse nextdata_n for 1 cycle → ready=0, data=0x00.
- **Bad parity.** Send 0x1C with parity=1 → ready stays 0, err_cnt=1. Then send 0x32 correctly → data=0x32.
- **Overflow.** Send 0x01..0x09 with no pops (DEPTH=8) → overflow=1. Popping returns 0x01..0x08 in order, then ready=0; 0x09 is absent.
- **Pointer wrap.** Interleave 20 frames with a pop after each → every byte is returned in order, overflow=0, and ready=0 at the end.
- **Timeout resync.** Send 5 bits, idle for TIMEOUT+10 cycles, then send a full frame 0xF0 → data=0xF0, err_cnt=0.
- **Reset mid-frame.** Assert rst after 6 bits of a frame, release it, then send 0x1C → only 0x1C is in the FIFO, err_cnt=0, overflow=0.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deserialises 11-bit
// frames, checks start/parity/stop and buffers good scan codes in a FIFO.
module ps2_kbd_rx #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic [7:0] err_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT - 1);

  logic [2:0]    ps2c_q;
  logic [1:0]    ps2d_q;
  logic [3:0]    cnt_q, cnt_d;
  logic [9:0]    shbuf_q, shbuf_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    err_q, err_d;
  logic [7:0]    mem_q [DEPTH];

  logic fall, data_s, frame_good, frame_ok, frame_bad;
  logic empty, full, wr_en, pop;

  assign fall       = (ps2c_q[2:1] == 2'b10);
  assign data_s     = ps2d_q[1];
  assign frame_good = !shbuf_q[0] && data_s && (^shbuf_q[9:1]);

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign wr_en = frame_ok && !full;
  assign pop   = !nextdata_n && !empty;

  assign ready    = !empty;
  assign data     = ready ? mem_q[rptr_q[AW-1:0]] : 8'h00;
  assign overflow = overflow_q;
  assign err_cnt  = err_q;

  always_comb begin
    cnt_d      = cnt_q;
    shbuf_d    = shbuf_q;
    idle_d     = idle_q;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    if (fall) begin
      idle_d = '0;
      if (cnt_q == 4'd10) begin
        cnt_d = '0;
        if (frame_good) frame_ok  = 1'b1;
        else            frame_bad = 1'b1;
      end else begin
        shbuf_d[cnt_q] = data_s;
        cnt_d          = cnt_q + 4'd1;
      end
    end else if (cnt_q != '0) begin
      // stalled partial frame is dropped silently; idle count only runs mid-frame
      if (idle_q == IDLE_LIMIT) begin
        cnt_d  = '0;
        idle_d = '0;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end else begin
      idle_d = '0;
    end
  end

  always_comb begin
    wptr_d     = wptr_q + (AW+1)'(wr_en);
    rptr_d     = rptr_q + (AW+1)'(pop);
    overflow_d = overflow_q | (frame_ok && full);
    err_d      = (frame_bad && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps2c_q     <= '1;
      ps2d_q     <= '1;
      cnt_q      <= '0;
      shbuf_q    <= '0;
      idle_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
      err_q      <= '0;
    end else begin
      ps2c_q     <= {ps2c_q[1:0], ps2_clk};
      ps2d_q     <= {ps2d_q[0], ps2_data};
      cnt_q      <= cnt_d;
      shbuf_q    <= shbuf_d;
      idle_q     <= idle_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= shbuf_q[8:1];
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: bytes expected in the FIFO are queued as
// frames are sent and compared as they are popped.
module tb_ps2_kbd_rx;

  localparam int unsigned TB_DEPTH   = 8;
  localparam int unsigned TB_TIMEOUT = 200;
  localparam int unsigned HALF       = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic [7:0] err_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0]  exp_q[$];
  logic        exp_ovf = 1'b0;
  int unsigned exp_err = 0;

  ps2_kbd_rx #(.DEPTH(TB_DEPTH), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
    mk_frame = {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] fr, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk) ps2_data = fr[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    send_bits(mk_frame(b, bad_par), 11);
    if (bad_par) begin
      if (exp_err < 255) exp_err++;
    end else if (exp_q.size() < TB_DEPTH) begin
      exp_q.push_back(b);
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_eq({tag, "_unexpected_pop"}, 32'(ready), 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_ready"}, 32'(ready), 32'd1);
      check_eq({tag, "_data"}, 32'(data), 32'(e));
      nextdata_n = 1'b0;
      @(negedge clk);
      nextdata_n = 1'b1;
    end
  endtask

  task automatic drain_check(input string tag);
    while (exp_q.size() != 0) pop_check(tag);
    @(negedge clk);
    check_eq({tag, "_empty_ready"}, 32'(ready), 32'd0);
    check_eq({tag, "_empty_data"}, 32'(data), 32'h00);
  endtask

  task automatic status_check(input string tag);
    check_eq({tag, "_err_cnt"}, 32'(err_cnt), exp_err);
    check_eq({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_err = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_data", 32'(data), 32'h00);
    check_eq("reset_ready", 32'(ready), 32'd0);
    status_check("reset");

    // pop request while empty must be ignored
    nextdata_n = 1'b0;
    repeat (2) @(negedge clk);
    nextdata_n = 1'b1;
    check_eq("empty_pop_ready", 32'(ready), 32'd0);

    // single frame
    send_byte(8'h1C, 1'b0);
    check_eq("single_ready", 32'(ready), 32'd1);
    status_check("single");
    drain_check("single");

    // bad parity then a good frame
    send_byte(8'h1C, 1'b1);
    check_eq("badpar_ready", 32'(ready), 32'd0);
    status_check("badpar");
    send_byte(8'h32, 1'b0);
    drain_check("after_badpar");

    // pointer wrap
    for (int unsigned i = 0; i < 20; i++) begin
      send_byte(8'(8'h40 + 8'(i * 7)), 1'b0);
      pop_check("wrap");
    end
    drain_check("wrap");
    status_check("wrap");

    // back-to-back pops with nextdata_n held low
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    @(negedge clk) nextdata_n = 1'b0;
    check_eq("burst_d0", 32'(data), 32'(exp_q.pop_front()));
    @(negedge clk);
    check_eq("burst_d1", 32'(data), 32'(exp_q.pop_front()));
    @(negedge clk) nextdata_n = 1'b1;
    check_eq("burst_ready", 32'(ready), 32'd0);

    // timeout resync
    send_bits(mk_frame(8'h77, 1'b0), 5);
    repeat (TB_TIMEOUT + 10) @(negedge clk);
    send_byte(8'hF0, 1'b0);
    status_check("timeout");
    drain_check("timeout");

    // reset mid-frame
    send_bits(mk_frame(8'hAA, 1'b0), 6);
    do_reset();
    send_byte(8'h1C, 1'b0);
    status_check("midrst");
    drain_check("midrst");

    // overflow
    for (int unsigned i = 1; i <= 9; i++) send_byte(8'(i), 1'b0);
    status_check("overflow");
    drain_check("overflow");
    status_check("overflow_after_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
